// File: rtl/amp_ui_event_gen_if.sv
// Signal bundle between the switch/key front end and the VGA plotter command port.
// The controller side drives raw inputs; the event generator is the slave.
interface amp_ui_event_gen_if;
  logic       sw_volume;
  logic       sw_pitch;
  logic       sw_distortion;
  logic       key_up_n;
  logic       key_down_n;
  logic [1:0] sel;
  logic       plot_busy;

  logic       VolumeTurnedOn;
  logic       VolumeTurnedOff;
  logic       PitchTurnedOn;
  logic       PitchTurnedOff;
  logic       DistortionTurnedOn;
  logic       DistortionTurnedOff;
  logic       EffectGo;
  logic       VolumeGo;
  logic       PitchGo;
  logic       DistortionGo;
  logic [6:0] volume_data;
  logic [6:0] pitch_data;
  logic [6:0] distortion_data;

  modport master (
    output sw_volume, sw_pitch, sw_distortion, key_up_n, key_down_n, sel, plot_busy,
    input  VolumeTurnedOn, VolumeTurnedOff, PitchTurnedOn, PitchTurnedOff,
           DistortionTurnedOn, DistortionTurnedOff, EffectGo, VolumeGo, PitchGo,
           DistortionGo, volume_data, pitch_data, distortion_data
  );

  modport slave (
    input  sw_volume, sw_pitch, sw_distortion, key_up_n, key_down_n, sel, plot_busy,
    output VolumeTurnedOn, VolumeTurnedOff, PitchTurnedOn, PitchTurnedOff,
           DistortionTurnedOn, DistortionTurnedOff, EffectGo, VolumeGo, PitchGo,
           DistortionGo, volume_data, pitch_data, distortion_data
  );
endinterface

// File: rtl/amp_ui_event_gen.sv
// Turns effect switches and level keys into one-cycle plotter commands, queued while the
// plotter is busy and issued one at a time in fixed priority with a hold-off between them.
module amp_ui_event_gen #(
  parameter int unsigned HOLDOFF    = 32,
  parameter logic [6:0]  LEVEL_STEP = 7'd5,
  parameter logic [6:0]  LEVEL_MAX  = 7'd100,
  parameter logic [6:0]  LEVEL_INIT = 7'd50
) (
  input logic              clk,
  input logic              rst_n,
  amp_ui_event_gen_if.slave bus
);

  localparam int unsigned     HoldW    = $clog2(HOLDOFF);
  localparam logic [HoldW-1:0] HoldLoad = HoldW'(HOLDOFF - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StGo, StHold} state_e;

  logic [2:0] sw_meta, sw_sync, sw_prev;
  logic [1:0] key_meta, key_sync, key_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      sw_prev  <= '0;
      key_meta <= '1;
      key_sync <= '1;
      key_prev <= '1;
    end else begin
      sw_meta  <= {bus.sw_distortion, bus.sw_pitch, bus.sw_volume};
      sw_sync  <= sw_meta;
      sw_prev  <= sw_sync;
      key_meta <= {bus.key_down_n, bus.key_up_n};
      key_sync <= key_meta;
      key_prev <= key_sync;
    end
  end

  logic [2:0]      sw_rise, sw_fall;
  logic            up_press, down_press, key_act;
  logic [3:0]      sw_en;
  logic [6:0]      cur_lvl, new_lvl;
  logic [7:0]      up_sum, dn_diff;
  logic [2:0][6:0] lvl_q, lvl_d;
  logic [2:0]      lvl_set;

  assign sw_rise    = sw_sync & ~sw_prev;
  assign sw_fall    = ~sw_sync & sw_prev;
  assign up_press   = key_prev[0] & ~key_sync[0];
  assign down_press = key_prev[1] & ~key_sync[1];
  // sel == 3 lands on the constant-0 entry, so it never enables a level change
  assign sw_en      = {1'b0, sw_sync};
  assign key_act    = (up_press ^ down_press) & sw_en[bus.sel];

  always_comb begin
    cur_lvl = '0;
    case (bus.sel)
      2'd0:    cur_lvl = lvl_q[0];
      2'd1:    cur_lvl = lvl_q[1];
      2'd2:    cur_lvl = lvl_q[2];
      default: cur_lvl = '0;
    endcase
    up_sum  = {1'b0, cur_lvl} + {1'b0, LEVEL_STEP};
    dn_diff = {1'b0, cur_lvl} - {1'b0, LEVEL_STEP};
    if (up_press) begin
      new_lvl = (up_sum > {1'b0, LEVEL_MAX}) ? LEVEL_MAX : up_sum[6:0];
    end else begin
      new_lvl = dn_diff[7] ? 7'd0 : dn_diff[6:0];
    end
    lvl_d   = lvl_q;
    lvl_set = '0;
    for (int e = 0; e < 3; e++) begin
      if (key_act && bus.sel == 2'(e)) begin
        lvl_d[e]   = new_lvl;
        lvl_set[e] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lvl_q <= {3{LEVEL_INIT}};
    else        lvl_q <= lvl_d;
  end

  // Pending bits in issue priority, bit 0 first:
  // VolOn, VolOff, PitOn, PitOff, DistOn, DistOff, LvlVol, LvlPit, LvlDist.
  state_e          state_q;
  logic [HoldW-1:0] hold_q;
  logic [8:0]      pend_q, pend_d, pend_set, pend_kill, pick, clr;
  logic            issue;

  assign pend_set  = {lvl_set, sw_fall[2], sw_rise[2], sw_fall[1], sw_rise[1],
                      sw_fall[0], sw_rise[0]};
  assign pend_kill = {3'b000, sw_rise[2], sw_fall[2], sw_rise[1], sw_fall[1],
                      sw_rise[0], sw_fall[0]};
  assign issue     = (state_q == StIdle) && (|pend_q) && !bus.plot_busy && (hold_q == '0);
  assign pick      = pend_q & (~pend_q + 9'd1);
  assign clr       = issue ? pick : 9'd0;
  // A set arriving on the issue cycle survives the clear and stays pending
  assign pend_d    = (pend_q & ~pend_kill & ~clr) | pend_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;
  end

  logic [9:0]      pulse_q;
  logic [2:0]      go_sel_q;
  logic [2:0][6:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      hold_q   <= '0;
      go_sel_q <= '0;
      pulse_q  <= '0;
      data_q   <= {3{LEVEL_INIT}};
    end else begin
      pulse_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (issue) begin
            state_q       <= StIssue;
            pulse_q[5:0]  <= pick[5:0];
            pulse_q[6]    <= |pick[8:6];
            go_sel_q      <= pick[8:6];
            for (int e = 0; e < 3; e++) begin
              if (pick[6+e]) data_q[e] <= lvl_q[e];
            end
          end
        end
        StIssue: begin
          if (|go_sel_q) begin
            state_q      <= StGo;
            pulse_q[9:7] <= go_sel_q;
          end else begin
            state_q <= StHold;
            hold_q  <= HoldLoad;
          end
        end
        StGo: begin
          state_q <= StHold;
          hold_q  <= HoldLoad;
        end
        StHold: begin
          if (hold_q == '0) state_q <= StIdle;
          else              hold_q  <= hold_q - HoldW'(1);
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.VolumeTurnedOn      = pulse_q[0];
  assign bus.VolumeTurnedOff     = pulse_q[1];
  assign bus.PitchTurnedOn       = pulse_q[2];
  assign bus.PitchTurnedOff      = pulse_q[3];
  assign bus.DistortionTurnedOn  = pulse_q[4];
  assign bus.DistortionTurnedOff = pulse_q[5];
  assign bus.EffectGo            = pulse_q[6];
  assign bus.VolumeGo            = pulse_q[7];
  assign bus.PitchGo             = pulse_q[8];
  assign bus.DistortionGo        = pulse_q[9];
  assign bus.volume_data         = data_q[0];
  assign bus.pitch_data          = data_q[1];
  assign bus.distortion_data     = data_q[2];

endmodule
